bht_update_ctrl: RTL and testbench

- Controller for the branch history table's single write port.
- Accepts resolved-branch outcomes from EX through a valid/ready handshake and buffers them in a small FIFO.
- Sequences table updates one per cycle, and runs a clear sweep of every entry after reset or on a flush request.
- Holds IF-stage predictions at not-taken until the table is valid, and keeps branch and mispredict statistics.

---
 rtl/bht_pkg.sv | 20 ++
 rtl/bht_upd_fifo.sv | 59 +++++
 rtl/bht_update_ctrl.sv | 124 ++++++++++++
 tb/tb_bht_update_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bht_pkg.sv
// Shared types and constants for the branch history table update path.
package bht_pkg;

    localparam int unsigned BHT_INDEX_W = 5;

    // Value the table holds in an entry after a clear write.
    localparam logic [1:0] BHT_CLEAR_STATE = 2'b00;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } bht_state_t;

    // One pending table update at the default index width.
    typedef struct packed {
        logic [BHT_INDEX_W-1:0] idx;
        logic                   taken;
    } bht_upd_t;

endpackage

// File: rtl/bht_upd_fifo.sv
// Small synchronous FIFO holding pending table updates; head is visible combinationally.
module bht_upd_fifo
    import bht_pkg::*;
#(
    parameter int unsigned DATA_W = $bits(bht_upd_t),
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bht_update_ctrl.sv
// Branch history table write-port controller: clear sweep, update FIFO, statistics.
module bht_update_ctrl
    import bht_pkg::*;
#(
    parameter int unsigned INDEX_W    = BHT_INDEX_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_req,
    input  logic               res_valid,
    output logic               res_ready,
    input  logic [INDEX_W-1:0] res_idx,
    input  logic               res_is_branch,
    input  logic               res_taken,
    input  logic               res_predicted,
    output logic               tbl_wr_en,
    output logic [INDEX_W-1:0] tbl_wr_idx,
    output logic               tbl_wr_inc,
    output logic               tbl_wr_clear,
    output logic               pred_enable,
    output logic               busy,
    output logic [CNT_W-1:0]   branch_cnt,
    output logic [CNT_W-1:0]   mispred_cnt
);

    localparam int unsigned ENTRY_W  = INDEX_W + 1;
    localparam int unsigned FCOUNT_W = $clog2(FIFO_DEPTH) + 1;

    bht_state_t            state;
    logic [INDEX_W-1:0]    sweep_idx;
    logic [ENTRY_W-1:0]    head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FCOUNT_W-1:0]   fifo_count;
    logic                  handshake;
    logic                  accept_branch;
    logic                  push;
    logic                  pop;

    // Ready and busy decode from registered state only.
    assign res_ready     = (state == RUN) && !fifo_full;
    assign busy          = (state == SWEEP) || (fifo_count != '0);
    assign handshake     = res_valid & res_ready;
    assign accept_branch = handshake & res_is_branch;
    assign push          = accept_branch & ~flush_req;
    assign pop           = (state == RUN) & ~fifo_empty & ~flush_req;

    bht_upd_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush_req),
        .push  (push),
        .pop   (pop),
        .din   ({res_idx, res_taken}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sweep/run sequencing with registered table-write outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SWEEP;
            sweep_idx    <= '0;
            tbl_wr_en    <= 1'b0;
            tbl_wr_clear <= 1'b0;
            tbl_wr_idx   <= '0;
            tbl_wr_inc   <= 1'b0;
            pred_enable  <= 1'b0;
        end else begin
            tbl_wr_en    <= 1'b0;
            tbl_wr_clear <= 1'b0;
            if (flush_req) begin
                state       <= SWEEP;
                sweep_idx   <= '0;
                pred_enable <= 1'b0;
            end else begin
                case (state)
                    SWEEP: begin
                        tbl_wr_en    <= 1'b1;
                        tbl_wr_clear <= 1'b1;
                        tbl_wr_idx   <= sweep_idx;
                        tbl_wr_inc   <= 1'b0;
                        sweep_idx    <= sweep_idx + INDEX_W'(1);
                        if (sweep_idx == '1) begin
                            state       <= RUN;
                            pred_enable <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (pop) begin
                            tbl_wr_en  <= 1'b1;
                            tbl_wr_idx <= head[ENTRY_W-1:1];
                            tbl_wr_inc <= head[0];
                        end
                    end
                    default: state <= SWEEP;
                endcase
            end
        end
    end

    // Saturating statistics; flush leaves them intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (accept_branch) begin
            if (branch_cnt != '1) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if ((res_taken != res_predicted) && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed self-checking bench for bht_update_ctrl and its update FIFO.
module tb_bht_update_ctrl;

    logic        clk;
    logic        rst;
    logic        flush_req;
    logic        res_valid;
    logic        res_ready;
    logic [4:0]  res_idx;
    logic        res_is_branch;
    logic        res_taken;
    logic        res_predicted;
    logic        tbl_wr_en;
    logic [4:0]  tbl_wr_idx;
    logic        tbl_wr_inc;
    logic        tbl_wr_clear;
    logic        pred_enable;
    logic        busy;
    logic [15:0] branch_cnt;
    logic [15:0] mispred_cnt;

    logic        f_rst;
    logic        f_clear;
    logic        f_push;
    logic        f_pop;
    logic [5:0]  f_din;
    logic [5:0]  f_dout;
    logic        f_full;
    logic        f_empty;
    logic [2:0]  f_count;

    int checks;
    int failures;

    bht_update_ctrl #(
        .INDEX_W    (5),
        .FIFO_DEPTH (4),
        .CNT_W      (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_req     (flush_req),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_idx       (res_idx),
        .res_is_branch (res_is_branch),
        .res_taken     (res_taken),
        .res_predicted (res_predicted),
        .tbl_wr_en     (tbl_wr_en),
        .tbl_wr_idx    (tbl_wr_idx),
        .tbl_wr_inc    (tbl_wr_inc),
        .tbl_wr_clear  (tbl_wr_clear),
        .pred_enable   (pred_enable),
        .busy          (busy),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    bht_upd_fifo #(
        .DATA_W (6),
        .DEPTH  (4)
    ) fifo_dut (
        .clk   (clk),
        .rst   (f_rst),
        .clear (f_clear),
        .push  (f_push),
        .pop   (f_pop),
        .din   (f_din),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush_req     = 1'b0;
        res_valid     = 1'b0;
        res_idx       = 5'd0;
        res_is_branch = 1'b0;
        res_taken     = 1'b0;
        res_predicted = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_wr_en"},   32'(tbl_wr_en),    32'd0);
        chk({tag, "_clear"},   32'(tbl_wr_clear), 32'd0);
        chk({tag, "_idx"},     32'(tbl_wr_idx),   32'd0);
        chk({tag, "_inc"},     32'(tbl_wr_inc),   32'd0);
        chk({tag, "_ready"},   32'(res_ready),    32'd0);
        chk({tag, "_pred_en"}, 32'(pred_enable),  32'd0);
        chk({tag, "_busy"},    32'(busy),         32'd1);
        chk({tag, "_brcnt"},   32'(branch_cnt),   32'd0);
        chk({tag, "_mpcnt"},   32'(mispred_cnt),  32'd0);
    endtask

    // Expects the 32 clear writes 0..31 on consecutive cycles, RUN entered with the last one.
    task automatic check_sweep(input string tag);
        for (int k = 0; k < 32; k++) begin
            step();
            chk({tag, "_wr_en"}, 32'(tbl_wr_en),    32'd1);
            chk({tag, "_clear"}, 32'(tbl_wr_clear), 32'd1);
            chk({tag, "_idx"},   32'(tbl_wr_idx),   32'(k));
            chk({tag, "_ready"}, 32'(res_ready),    (k == 31) ? 32'd1 : 32'd0);
            chk({tag, "_pred"},  32'(pred_enable),  (k == 31) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();
        f_rst   = 1'b1;
        f_clear = 1'b0;
        f_push  = 1'b0;
        f_pop   = 1'b0;
        f_din   = 6'd0;

        // Reset and release into the clear sweep.
        rst = 1'b1;
        step();
        step();
        check_reset_state("reset");
        rst = 1'b0;
        check_sweep("sweep0");

        // Single mispredicted taken branch to idx 7.
        res_valid = 1'b1; res_is_branch = 1'b1; res_idx = 5'd7;
        res_taken = 1'b1; res_predicted = 1'b0;
        step();
        idle_inputs();
        chk("single_brcnt", 32'(branch_cnt),  32'd1);
        chk("single_mpcnt", 32'(mispred_cnt), 32'd1);
        chk("single_nowr",  32'(tbl_wr_en),   32'd0);
        chk("single_busy",  32'(busy),        32'd1);
        step();
        chk("single_wr_en", 32'(tbl_wr_en),    32'd1);
        chk("single_idx",   32'(tbl_wr_idx),   32'd7);
        chk("single_inc",   32'(tbl_wr_inc),   32'd1);
        chk("single_clear", 32'(tbl_wr_clear), 32'd0);
        step();
        chk("single_idle_wr", 32'(tbl_wr_en), 32'd0);
        chk("single_idle_busy", 32'(busy),    32'd0);

        // Six back-to-back branches idx 1..6, taken on odd idx, predicted not-taken.
        for (int i = 1; i <= 6; i++) begin
            res_valid = 1'b1; res_is_branch = 1'b1; res_idx = 5'(i);
            res_taken = 1'(i % 2); res_predicted = 1'b0;
            #1;
            chk("stream_ready", 32'(res_ready), 32'd1);
            step();
            if (i >= 2) begin
                chk("stream_wr_en", 32'(tbl_wr_en),  32'd1);
                chk("stream_idx",   32'(tbl_wr_idx), 32'(i - 1));
                chk("stream_inc",   32'(tbl_wr_inc), 32'((i - 1) % 2));
            end
        end
        idle_inputs();
        step();
        chk("stream_last_idx", 32'(tbl_wr_idx),  32'd6);
        chk("stream_last_inc", 32'(tbl_wr_inc),  32'd0);
        chk("stream_brcnt",    32'(branch_cnt),  32'd7);
        chk("stream_mpcnt",    32'(mispred_cnt), 32'd4);
        step();
        chk("stream_drained", 32'(tbl_wr_en), 32'd0);

        // Non-branch handshakes are accepted and dropped.
        for (int i = 0; i < 3; i++) begin
            res_valid = 1'b1; res_is_branch = 1'b0; res_idx = 5'(20 + i);
            res_taken = 1'b1; res_predicted = 1'b0;
            #1;
            chk("nb_ready", 32'(res_ready), 32'd1);
            step();
            chk("nb_nowr", 32'(tbl_wr_en), 32'd0);
        end
        idle_inputs();
        step();
        chk("nb_nowr_after", 32'(tbl_wr_en),   32'd0);
        chk("nb_brcnt",      32'(branch_cnt),  32'd7);
        chk("nb_mpcnt",      32'(mispred_cnt), 32'd4);

        // Flush with one pending update plus a same-cycle handshake.
        res_valid = 1'b1; res_is_branch = 1'b1; res_idx = 5'd9;
        res_taken = 1'b1; res_predicted = 1'b1;
        step();
        res_idx = 5'd10; res_taken = 1'b0; res_predicted = 1'b1;
        flush_req = 1'b1;
        #1;
        chk("flush_ready_pre", 32'(res_ready), 32'd1);
        step();
        idle_inputs();
        chk("flush_nowr",   32'(tbl_wr_en),   32'd0);
        chk("flush_ready",  32'(res_ready),   32'd0);
        chk("flush_pred",   32'(pred_enable), 32'd0);
        chk("flush_busy",   32'(busy),        32'd1);
        chk("flush_brcnt",  32'(branch_cnt),  32'd9);
        chk("flush_mpcnt",  32'(mispred_cnt), 32'd5);
        check_sweep("sweep1");
        chk("post_flush_brcnt", 32'(branch_cnt),  32'd9);
        chk("post_flush_mpcnt", 32'(mispred_cnt), 32'd5);
        step();
        chk("post_flush_nowr", 32'(tbl_wr_en), 32'd0);
        chk("post_flush_busy", 32'(busy),      32'd0);

        // Flush from RUN, then flush again at sweep_idx=10.
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("partial_idx", 32'(tbl_wr_idx), 32'(k));
        end
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        chk("restart_nowr", 32'(tbl_wr_en), 32'd0);
        check_sweep("sweep2");

        // Reset and flush together behave as a plain reset.
        rst = 1'b1;
        flush_req = 1'b1;
        step();
        check_reset_state("rstflush");
        rst = 1'b0;
        flush_req = 1'b0;
        step();
        chk("rstflush_first_idx",   32'(tbl_wr_idx),   32'd0);
        chk("rstflush_first_clear", 32'(tbl_wr_clear), 32'd1);

        // Standalone FIFO: fill to full, then drain in order.
        f_rst = 1'b1;
        step();
        f_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            f_push = 1'b1;
            f_din  = 6'(8'h11 + i);
            step();
        end
        f_push = 1'b0;
        chk("fifo_full",  32'(f_full),  32'd1);
        chk("fifo_count", 32'(f_count), 32'd4);
        f_push = 1'b1;
        f_din  = 6'h3f;
        step();
        f_push = 1'b0;
        chk("fifo_full_hold", 32'(f_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("fifo_head", 32'(f_dout), 32'(6'(8'h11 + i)));
            f_pop = 1'b1;
            step();
        end
        f_pop = 1'b0;
        chk("fifo_empty", 32'(f_empty), 32'd1);
        chk("fifo_count0", 32'(f_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
